// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box scheduler types: data widths, owner/state enums and request sizes.
package aes_sbox_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic { OWNER_KS = 1'b0, OWNER_ST = 1'b1 } sched_owner_e;
  typedef enum logic { S_IDLE   = 1'b0, S_BUSY   = 1'b1 } sched_state_e;

  localparam int KS_BYTES = 4;
  localparam int ST_BYTES = 16;

endpackage

// File: rtl/sbox_scheduler_if.sv
// Request/response bundle between the two AES consumers and the S-box scheduler.
interface sbox_scheduler_if;
  import aes_sbox_pkg::*;

  // Handshake: a request transfers on a clock edge where valid and ready are both high.
  // Ready may depend combinationally on valid; requesters must not wait for ready to raise valid.
  // Responses are a one-cycle rsp_valid pulse with no backpressure; rsp data holds until the next pulse.
  logic   ks_req_valid;
  word_t  ks_req_word;
  logic   ks_req_ready;
  logic   ks_rsp_valid;
  word_t  ks_rsp_word;

  logic   st_req_valid;
  state_t st_req_data;
  logic   st_req_ready;
  logic   st_rsp_valid;
  state_t st_rsp_data;

  logic   busy;

  modport master (
    output ks_req_valid, ks_req_word, st_req_valid, st_req_data,
    input  ks_req_ready, ks_rsp_valid, ks_rsp_word,
    input  st_req_ready, st_rsp_valid, st_rsp_data, busy
  );

  modport slave (
    input  ks_req_valid, ks_req_word, st_req_valid, st_req_data,
    output ks_req_ready, ks_rsp_valid, ks_rsp_word,
    output st_req_ready, st_rsp_valid, st_rsp_data, busy
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0x00 sits in the most significant byte so the table reads in FIPS-197 order.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] rev_idx;

  assign rev_idx = ~in_i;
  assign out_o   = SBOX_TABLE[{rev_idx, 3'b000} +: 8];

endmodule

// File: rtl/sbox_sched_arb.sv
// Grant logic for the S-box scheduler. Define SBOX_SCHED_RR_EN for round-robin on contention;
// otherwise key schedule has fixed priority.
module sbox_sched_arb
  import aes_sbox_pkg::*;
(
`ifdef SBOX_SCHED_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic idle_i,
  input  logic ks_valid_i,
  input  logic st_valid_i,
  output logic ks_ready_o,
  output logic st_ready_o,
  output logic ks_accept_o,
  output logic st_accept_o
);

  logic ks_wins;

`ifdef SBOX_SCHED_RR_EN
  sched_owner_e last_grant_q;

  // Reset to ST so the very first contention is granted to the key schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWNER_ST;
    end else if (ks_accept_o) begin
      last_grant_q <= OWNER_KS;
    end else if (st_accept_o) begin
      last_grant_q <= OWNER_ST;
    end
  end

  assign ks_wins = !(st_valid_i && (last_grant_q == OWNER_KS));
`else
  assign ks_wins = 1'b1;
`endif

  assign ks_ready_o  = idle_i && ks_wins;
  assign st_ready_o  = idle_i && !(ks_valid_i && ks_wins);
  assign ks_accept_o = ks_valid_i && ks_ready_o;
  assign st_accept_o = st_valid_i && st_ready_o;

endmodule

// File: rtl/sbox_scheduler.sv
// Shares LANES AES S-boxes between SubWord (32-bit) and SubBytes (128-bit) requests, chunk by chunk.
// Optional round-robin arbitration: define SBOX_SCHED_RR_EN.
module sbox_scheduler
  import aes_sbox_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sbox_scheduler_if.slave   bus,
  output sched_state_e      state_o
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("sbox_scheduler: LANES must be 1, 2 or 4");
  end

  localparam int KS_CHUNKS = KS_BYTES / LANES;
  localparam int ST_CHUNKS = ST_BYTES / LANES;

  sched_state_e state_q;
  sched_owner_e owner_q;
  logic [3:0]   cnt_q;
  state_t       buf_q;
  word_t        ks_rsp_q, ks_rsp_d;
  state_t       st_rsp_q, st_rsp_d;
  logic         ks_vld_q, st_vld_q;

  logic         idle, last_chunk;
  logic         ks_accept, st_accept;
  logic [3:0]   byte_idx [LANES];
  byte_t        sbox_in  [LANES];
  byte_t        sbox_out [LANES];

  assign idle = (state_q == S_IDLE);

  sbox_sched_arb u_arb (
`ifdef SBOX_SCHED_RR_EN
    .clk         (clk),
    .rst_n       (rst_n),
`endif
    .idle_i      (idle),
    .ks_valid_i  (bus.ks_req_valid),
    .st_valid_i  (bus.st_req_valid),
    .ks_ready_o  (bus.ks_req_ready),
    .st_ready_o  (bus.st_req_ready),
    .ks_accept_o (ks_accept),
    .st_accept_o (st_accept)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign byte_idx[g] = cnt_q * 4'(LANES) + 4'(g);
    assign sbox_in[g]  = buf_q[{byte_idx[g], 3'b000} +: 8];
    sbox u_sbox (.in_i(sbox_in[g]), .out_o(sbox_out[g]));
  end

  // KS chunks never address past byte 3, so the low two index bits select within the word.
  always_comb begin
    ks_rsp_d = ks_rsp_q;
    st_rsp_d = st_rsp_q;
    for (int l = 0; l < LANES; l++) begin
      ks_rsp_d[{byte_idx[l][1:0], 3'b000} +: 8] = sbox_out[l];
      st_rsp_d[{byte_idx[l], 3'b000} +: 8]      = sbox_out[l];
    end
  end

  assign last_chunk = (owner_q == OWNER_KS) ? (cnt_q == 4'(KS_CHUNKS - 1))
                                            : (cnt_q == 4'(ST_CHUNKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= OWNER_KS;
      cnt_q    <= '0;
      buf_q    <= '0;
      ks_rsp_q <= '0;
      st_rsp_q <= '0;
      ks_vld_q <= 1'b0;
      st_vld_q <= 1'b0;
    end else begin
      ks_vld_q <= 1'b0;
      st_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ks_accept) begin
            buf_q   <= {96'b0, bus.ks_req_word};
            owner_q <= OWNER_KS;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end else if (st_accept) begin
            buf_q   <= bus.st_req_data;
            owner_q <= OWNER_ST;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (owner_q == OWNER_KS) ks_rsp_q <= ks_rsp_d;
          else                     st_rsp_q <= st_rsp_d;
          if (last_chunk) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (owner_q == OWNER_KS) ks_vld_q <= 1'b1;
            else                     st_vld_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ks_rsp_valid = ks_vld_q;
  assign bus.ks_rsp_word  = ks_rsp_q;
  assign bus.st_rsp_valid = st_vld_q;
  assign bus.st_rsp_data  = st_rsp_q;
  assign bus.busy         = (state_q == S_BUSY);
  assign state_o          = state_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler at LANES=4 and LANES=1; honours SBOX_SCHED_RR_EN for arbitration.
module tb_sbox_scheduler;
  import aes_sbox_pkg::*;

  localparam logic [31:0]  KS_IN  = 32'h00010203;
  localparam logic [31:0]  KS_OUT = 32'h637C777B;
  localparam logic [31:0]  FF_IN  = 32'hFFFFFFFF;
  localparam logic [31:0]  FF_OUT = 32'h16161616;
  localparam logic [31:0]  W3_IN  = 32'h11223344;
  localparam logic [31:0]  W3_OUT = 32'h8293C31B;
  localparam logic [127:0] ST_IN  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] ST_OUT = 128'h638293C31BFC33F5C4EEACEA4BC12816;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_scheduler_if b4 ();
  sbox_scheduler_if b1 ();
  sched_state_e state4, state1;

  sbox_scheduler #(.LANES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave), .state_o(state4));
  sbox_scheduler #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .state_o(state1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard for the back-to-back KS stream on the LANES=4 instance
  logic [127:0] exp_q[$];
  int           rsp_cyc[$];
  bit           sb_en = 1'b0;
  int           st1_pulses = 0;

  always @(negedge clk) begin
    if (b1.st_rsp_valid) st1_pulses++;
    if (sb_en && b4.ks_rsp_valid) begin
      logic [127:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("sb_word", {96'b0, b4.ks_rsp_word}, e);
      rsp_cyc.push_back(cyc);
    end
  end

  // driver helpers
  task automatic drive_req(input int dut, input bit is_ks, input logic [127:0] data, input bit v);
    if (dut == 4) begin
      if (is_ks) begin b4.ks_req_valid = v; b4.ks_req_word = data[31:0]; end
      else       begin b4.st_req_valid = v; b4.st_req_data = data;       end
    end else begin
      if (is_ks) begin b1.ks_req_valid = v; b1.ks_req_word = data[31:0]; end
      else       begin b1.st_req_valid = v; b1.st_req_data = data;       end
    end
  endtask

  function automatic logic rsp_valid(input int dut, input bit is_ks);
    if (dut == 4) return is_ks ? b4.ks_rsp_valid : b4.st_rsp_valid;
    return is_ks ? b1.ks_rsp_valid : b1.st_rsp_valid;
  endfunction

  function automatic logic req_ready(input int dut, input bit is_ks);
    if (dut == 4) return is_ks ? b4.ks_req_ready : b4.st_req_ready;
    return is_ks ? b1.ks_req_ready : b1.st_req_ready;
  endfunction

  function automatic logic busy_of(input int dut);
    return (dut == 4) ? b4.busy : b1.busy;
  endfunction

  // One request from idle; returns latency in cycles from accept to rsp_valid, and busy cycles seen.
  task automatic run_op(input int dut, input bit is_ks, input logic [127:0] data,
                        output int lat, output int busy_cyc);
    @(posedge clk); #1;
    drive_req(dut, is_ks, data, 1'b1);
    #1 chk($sformatf("ready_d%0d_ks%0d", dut, is_ks), {127'b0, req_ready(dut, is_ks)}, 128'd1);
    @(posedge clk); #1;
    drive_req(dut, is_ks, '0, 1'b0);
    lat = -1;
    busy_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy_of(dut)) busy_cyc++;
      @(posedge clk); #1;
      if (rsp_valid(dut, is_ks)) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, p0, ng;
    logic [1:0] grants [4];
    logic [1:0] exp_g  [4];
    int acc [3];
    logic [31:0] b2b_w [3];

    b4.ks_req_valid = 1'b0; b4.ks_req_word = '0; b4.st_req_valid = 1'b0; b4.st_req_data = '0;
    b1.ks_req_valid = 1'b0; b1.ks_req_word = '0; b1.st_req_valid = 1'b0; b1.st_req_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state4", 128'(state4), 128'(S_IDLE));
    chk("rst_busy4", {127'b0, b4.busy}, 128'd0);
    chk("rst_ksv4", {127'b0, b4.ks_rsp_valid}, 128'd0);
    chk("rst_ksw4", {96'b0, b4.ks_rsp_word}, 128'd0);
    chk("rst_std4", b4.st_rsp_data, 128'd0);
    chk("rst_ksrdy4", {127'b0, b4.ks_req_ready}, 128'd1);
    chk("rst_strdy4", {127'b0, b4.st_req_ready}, 128'd1);
    chk("rst_std1", b1.st_rsp_data, 128'd0);
    rst_n = 1'b1;

    // KS SubWord at LANES=4
    run_op(4, 1'b1, {96'b0, KS_IN}, lat, bc);
    chk("ks4_lat", 128'(lat), 128'd1);
    chk("ks4_busy", 128'(bc), 128'd1);
    chk("ks4_word", {96'b0, b4.ks_rsp_word}, {96'b0, KS_OUT});
    chk("ks4_st_untouched", b4.st_rsp_data, 128'd0);
    @(posedge clk); #1;
    chk("ks4_pulse_end", {127'b0, b4.ks_rsp_valid}, 128'd0);
    chk("ks4_word_held", {96'b0, b4.ks_rsp_word}, {96'b0, KS_OUT});

    // ST SubBytes at LANES=4
    run_op(4, 1'b0, ST_IN, lat, bc);
    chk("st4_lat", 128'(lat), 128'd4);
    chk("st4_busy", 128'(bc), 128'd4);
    chk("st4_data", b4.st_rsp_data, ST_OUT);
    chk("st4_ks_untouched", {96'b0, b4.ks_rsp_word}, {96'b0, KS_OUT});
    @(posedge clk); #1;
    chk("st4_pulse_end", {127'b0, b4.st_rsp_valid}, 128'd0);

    // ST SubBytes at LANES=1
    p0 = st1_pulses;
    run_op(1, 1'b0, ST_IN, lat, bc);
    chk("st1_lat", 128'(lat), 128'd16);
    chk("st1_busy", 128'(bc), 128'd16);
    chk("st1_data", b1.st_rsp_data, ST_OUT);
    @(posedge clk); #1;
    chk("st1_pulse_end", {127'b0, b1.st_rsp_valid}, 128'd0);
    repeat (3) @(posedge clk);
    #1 chk("st1_pulse_count", 128'(st1_pulses - p0), 128'd1);

    // reset during ST chunk 2 at LANES=1
    p0 = st1_pulses;
    @(posedge clk); #1;
    drive_req(1, 1'b0, ST_IN, 1'b1);
    @(posedge clk); #1;
    drive_req(1, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    chk("rst_mid_busy_before", {127'b0, b1.busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state1", 128'(state1), 128'(S_IDLE));
    chk("rst_mid_busy1", {127'b0, b1.busy}, 128'd0);
    chk("rst_mid_std1", b1.st_rsp_data, 128'd0);
    chk("rst_mid_stv1", {127'b0, b1.st_rsp_valid}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_no_pulse", 128'(st1_pulses - p0), 128'd0);
    chk("rst_mid_std1_after", b1.st_rsp_data, 128'd0);
    run_op(1, 1'b1, {96'b0, FF_IN}, lat, bc);
    chk("ks1_lat", 128'(lat), 128'd4);
    chk("ks1_word", {96'b0, b1.ks_rsp_word}, {96'b0, FF_OUT});

    // contention on LANES=4 with both valids held
`ifdef SBOX_SCHED_RR_EN
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0; exp_g[3] = 2'd1;
`else
    exp_g[0] = 2'd0; exp_g[1] = 2'd0; exp_g[2] = 2'd0; exp_g[3] = 2'd0;
`endif
    @(posedge clk); #1;
    drive_req(4, 1'b1, {96'b0, W3_IN}, 1'b1);
    drive_req(4, 1'b0, ST_IN, 1'b1);
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (state4 == S_IDLE) begin
        if (b4.ks_req_ready)      grants[ng] = 2'd0;
        else if (b4.st_req_ready) grants[ng] = 2'd1;
        else                      grants[ng] = 2'd2;
        ng++;
      end
    end
    @(posedge clk); #1;
    drive_req(4, 1'b1, '0, 1'b0);
    drive_req(4, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && state4 != S_IDLE; i++) @(negedge clk);
    chk("arb_idle", 128'(state4), 128'(S_IDLE));
    chk("arb_grant_count", 128'(ng), 128'd4);
    for (int i = 0; i < ng; i++) chk($sformatf("arb_grant%0d", i), 128'(grants[i]), 128'(exp_g[i]));
    chk("arb_ksw", {96'b0, b4.ks_rsp_word}, {96'b0, W3_OUT});
`ifdef SBOX_SCHED_RR_EN
    chk("arb_std", b4.st_rsp_data, ST_OUT);
`else
    chk("arb_std", b4.st_rsp_data, 128'd0);
`endif

    // back-to-back KS at LANES=4
    repeat (3) @(posedge clk);
    b2b_w[0] = KS_IN; b2b_w[1] = FF_IN; b2b_w[2] = W3_IN;
    exp_q.push_back({96'b0, KS_OUT});
    exp_q.push_back({96'b0, FF_OUT});
    exp_q.push_back({96'b0, W3_OUT});
    sb_en = 1'b1;
    @(posedge clk); #1;
    b4.ks_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b4.ks_req_word = b2b_w[i];
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (b4.ks_req_ready) break;
      end
      chk($sformatf("b2b_ready%0d", i), {127'b0, b4.ks_req_ready}, 128'd1);
      if (i > 0) chk($sformatf("b2b_acc_in_rsp%0d", i), {127'b0, b4.ks_rsp_valid}, 128'd1);
      @(posedge clk); #1;
      acc[i] = cyc;
    end
    b4.ks_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sb_en = 1'b0;
    chk("b2b_acc_gap1", 128'(acc[1] - acc[0]), 128'd2);
    chk("b2b_acc_gap2", 128'(acc[2] - acc[1]), 128'd2);
    chk("b2b_exp_left", 128'(exp_q.size()), 128'd0);
    chk("b2b_rsp_count", 128'(rsp_cyc.size()), 128'd3);
    if (rsp_cyc.size() == 3) begin
      chk("b2b_rsp_gap1", 128'(rsp_cyc[1] - rsp_cyc[0]), 128'd2);
      chk("b2b_rsp_gap2", 128'(rsp_cyc[2] - rsp_cyc[1]), 128'd2);
    end
`ifdef SBOX_SCHED_RR_EN
    chk("b2b_st_untouched", b4.st_rsp_data, ST_OUT);
`else
    chk("b2b_st_untouched", b4.st_rsp_data, 128'd0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
